shift_cmd_sequencer: RTL and testbench
======================================

// Module: shift_cmd_sequencer
// PURPOSE
//  Upstream command stage for the N-bit shift register (ctrl[2:0]/in[N-1:0] -> out).
//  - Buffers {op, data, count} commands in a DEPTH-entry FIFO.
//  - Replays each command as `count` consecutive ctrl/in cycles into the register.
//  - Holds the register between commands: it drives ctrl=LOAD with in = register output.
//  - Returns register output on sr_q.
// PARAMETERS
//  N     8  data width; equals the shift register width
//  DEPTH 4  command FIFO entries; power of 2, >= 2
//  CW    4  width of repeat count field
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            reset, synchronous, active-high
//  cmd_valid  in   1            command offered
//  cmd_ready  out  1            FIFO can accept (level < DEPTH)
//  cmd_op     in   3            register op code 0..7 (0 clr,1 load,2 lsr,3 lsl,4 asr,5 ser-in,6 rotr,7 rotl)
//  cmd_data   in   N            operand (load value / serial-in bit source)
//  cmd_count  in   CW           repeat cycles; 0 treated as 1
//  sr_q       in   N            current shift register output
//  sr_ctrl    out  3            to register ctrl
//  sr_in      out  N            to register in
//  busy       out  1            command executing or FIFO non-empty
//  done       out  1            1-cycle pulse after a command's final op cycle
//  fifo_level out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  - Reset: FIFO empty, state IDLE, rep counter 0, done=0, busy=0, cmd_ready=0 while rst high.
//  - Reset: during and after reset, sr_ctrl=3'd1 and sr_in=sr_q (hold).
//  - Push: on edge with cmd_valid && cmd_ready; no push when full.
//  - Push and pop in the same cycle: level unchanged; data order preserved (FIFO).
//  - States:
//    - IDLE: drive hold (ctrl=1, in=sr_q).
//      - If FIFO non-empty: pop into exec regs {op,data,rem=max(count,1)}, k=0; -> RUN.
//    - RUN: drive sr_ctrl=op. Decrement rem and increment k each cycle.
//      - sr_in = data for op 1.
//      - sr_in = data >> k (bit k on in[0]; 0 once k>=N) for op 5.
//      - sr_in = 0 for all other ops (don't-care to the register, fixed for checking).
//  - Last RUN cycle (rem==1): done asserts at next edge for exactly 1 cycle.
//    - FIFO non-empty: pop next command at the same edge; RUN continues with no bubble.
//    - FIFO empty: -> IDLE.
//  - Latency: command pushed into empty FIFO in idle at edge E0 -> popped at E1 -> first op
//    driven E1..E2 -> applied by register at E2.
//  - Back-to-back: commands already queued run with zero idle cycles between them.
//  - Op cycles out per command = max(count,1); total register edges never skip or duplicate.
//  - busy = (state==RUN) | (level!=0); combinational from regs.
//  - k saturates at N (no wrap); rem counter is CW bits, max 2^CW-1 repeats.
//  - Reset mid-RUN: command aborted, FIFO flushed, no done pulse, outputs return to hold next cycle.
//  - sr_ctrl/sr_in are combinational from state/exec regs/sr_q; all state registered.
// TESTING
//  1. Reset, idle 5 cycles -> sr_ctrl=1, sr_in tracks sr_q, busy=0, done=0, cmd_ready=1 after rst drops.
//  2. Push {op1,data=8'hA5,cnt=1} -> register=A5 at E2; done high one cycle; then hold, register stays A5.
//  3. Load 8'h81, then {op7,cnt=3} queued behind it -> no bubble; register 81,03,06,0C; two done pulses.
//  4. Push {op5,data=8'b1011,cnt=4} on cleared register -> sr_in[0] = 1,1,0,1 per cycle; register = 8'hB0.
//  5. Hold cmd_valid with cnt=7 x6 cmds, DEPTH=4 -> cmd_ready drops at level 4; no push lost; 6 done pulses in order.
//  6. Assert rst mid-RUN of {op3,cnt=10} with 2 queued -> level=0, no done, sr_ctrl=1 next cycle.

Source files
------------

// File: rtl/shift_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_cmd_sequencer
//  Purpose  : Queues {op, data, count} commands and replays each as `count`
//             ctrl/in cycles into an N-bit shift register; holds it otherwise.
//  Revision : 1.0  initial release
// ============================================================================
module shift_cmd_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [N-1:0]             cmd_data,
    input  logic [CW-1:0]            cmd_count,
    input  logic [N-1:0]             sr_q,
    output logic [2:0]               sr_ctrl,
    output logic [N-1:0]             sr_in,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_KW = $clog2(N + 1);

    localparam logic [2:0] c_OP_LOAD  = 3'd1;
    localparam logic [2:0] c_OP_SERIN = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [2:0]      r_op_mem   [DEPTH];
    logic [N-1:0]    r_data_mem [DEPTH];
    logic [CW-1:0]   r_cnt_mem  [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_LW-1:0] r_level;

    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_last;
    logic [CW-1:0]   w_head_cnt;
    logic [CW-1:0]   w_head_rem;

    // Execution registers for the command currently being replayed
    logic [2:0]      r_op;
    logic [N-1:0]    r_data;
    logic [CW-1:0]   r_rem;
    logic [c_KW-1:0] r_k;
    logic            r_done;

    assign w_empty    = (r_level == '0);
    assign cmd_ready  = !rst && (r_level != c_LW'(DEPTH));
    assign w_push     = cmd_valid && cmd_ready;
    assign w_last     = (r_state == S_RUN) && (r_rem == CW'(1));
    // A pop happens from IDLE or on the final cycle of a command, so queued
    // commands chain with no idle cycle between them.
    assign w_pop      = !w_empty && ((r_state == S_IDLE) || w_last);
    assign w_head_cnt = r_cnt_mem[r_rptr];
    assign w_head_rem = (w_head_cnt == '0) ? CW'(1) : w_head_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wptr]   <= cmd_op;
            r_data_mem[r_wptr] <= cmd_data;
            r_cnt_mem[r_wptr]  <= cmd_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last && w_empty) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= '0;
            r_data <= '0;
            r_rem  <= '0;
            r_k    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_pop) begin
                r_op   <= r_op_mem[r_rptr];
                r_data <= r_data_mem[r_rptr];
                r_rem  <= w_head_rem;
                r_k    <= '0;
            end else if (r_state == S_RUN) begin
                r_rem <= r_rem - CW'(1);
                if (r_k != c_KW'(N)) begin
                    r_k <= r_k + c_KW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register drive: hold (load own output) unless a command is running
    // ------------------------------------------------------------------
    always_comb begin
        sr_ctrl = c_OP_LOAD;
        sr_in   = sr_q;
        if (r_state == S_RUN) begin
            sr_ctrl = r_op;
            case (r_op)
                c_OP_LOAD:  sr_in = r_data;
                c_OP_SERIN: sr_in = r_data >> r_k;
                default:    sr_in = '0;
            endcase
        end
    end

    assign busy       = (r_state == S_RUN) || !w_empty;
    assign done       = r_done;
    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_shift_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_cmd_sequencer
//  Purpose  : Scoreboard bench: sequencer driving a behavioural shift register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_cmd_sequencer;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [N-1:0]  cmd_data = '0;
    logic [CW-1:0] cmd_count = '0;
    logic [N-1:0]  sr_q;
    logic [2:0]    sr_ctrl;
    logic [N-1:0]  sr_in;
    logic          busy;
    logic          done;
    logic [2:0]    fifo_level;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int max_level = 0;
    logic [N-1:0] model_q = '0;
    logic [N-1:0] sb_q[$];

    shift_cmd_sequencer #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_count  (cmd_count),
        .sr_q       (sr_q),
        .sr_ctrl    (sr_ctrl),
        .sr_in      (sr_in),
        .busy       (busy),
        .done       (done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] sr_apply(input logic [2:0] op, input logic [N-1:0] in,
                                              input logic [N-1:0] q);
        case (op)
            3'd0:    return '0;
            3'd1:    return in;
            3'd2:    return q >> 1;
            3'd3:    return q << 1;
            3'd4:    return {q[N-1], q[N-1:1]};
            3'd5:    return {in[0], q[N-1:1]};
            3'd6:    return {q[0], q[N-1:1]};
            default: return {q[N-2:0], q[N-1]};
        endcase
    endfunction

    // Behavioural shift register driven by the sequencer
    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_apply(sr_ctrl, sr_in, sr_q);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_level == 3'(DEPTH)) check("ready_at_full", 32'(cmd_ready), 32'd0);
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (done) begin
                done_cnt++;
                if (sb_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
                else check("final_value", 32'(sr_q), 32'(sb_q.pop_front()));
            end
        end
    end

    // Offers one command and returns just after the edge that accepts it;
    // the expected final register value is queued at acceptance.
    task automatic push_cmd(input logic [2:0] op, input logic [N-1:0] d, input logic [CW-1:0] c);
        int wc = 0;
        int reps;
        logic [N-1:0] in;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = c;
        while (!cmd_ready && wc < 300) begin
            @(negedge clk);
            wc++;
        end
        if (!cmd_ready) check("push_timeout", 32'd0, 32'd1);
        reps = (c == 0) ? 1 : int'(c);
        for (int i = 0; i < reps; i++) begin
            in = (op == 3'd1) ? d : (op == 3'd5) ? ((i < N) ? (d >> i) : '0) : '0;
            model_q = sr_apply(op, in, model_q);
        end
        sb_q.push_back(model_q);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int wc = 0;
        @(negedge clk);
        while (busy && wc < 400) begin
            @(negedge clk);
            wc++;
        end
        if (busy) check("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        logic [3:0] ser_bits;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("ready_in_reset", 32'(cmd_ready), 32'd0);
        check("ctrl_in_reset", 32'(sr_ctrl), 32'd1);
        check("in_in_reset", 32'(sr_in), 32'(sr_q));
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("idle_ctrl", 32'(sr_ctrl), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_ready", 32'(cmd_ready), 32'd1);
        end

        // Single load: applied at E2, done one cycle, then hold
        push_cmd(3'd1, 8'hA5, 4'd1);
        check("busy_after_push", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("load_ctrl", 32'(sr_ctrl), 32'd1);
        check("load_in", 32'(sr_in), 32'hA5);
        @(posedge clk); #1;
        check("load_q_e2", 32'(sr_q), 32'hA5);
        check("load_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("load_done_pulse", 32'(done), 32'd0);
        check("load_hold_q", 32'(sr_q), 32'hA5);
        check("load_hold_busy", 32'(busy), 32'd0);
        wait_idle();

        // Load then rotl x3, no bubble
        d0 = done_cnt;
        push_cmd(3'd1, 8'h81, 4'd1);
        push_cmd(3'd7, 8'h00, 4'd3);
        @(posedge clk); #1;
        check("chain_q0", 32'(sr_q), 32'h81);
        check("chain_ctrl", 32'(sr_ctrl), 32'd7);
        check("chain_in_zero", 32'(sr_in), 32'd0);
        @(posedge clk); #1;
        check("chain_q1", 32'(sr_q), 32'h03);
        @(posedge clk); #1;
        check("chain_q2", 32'(sr_q), 32'h06);
        @(posedge clk); #1;
        check("chain_q3", 32'(sr_q), 32'h0C);
        wait_idle();
        check("chain_dones", 32'(done_cnt - d0), 32'd2);

        // Serial-in on a cleared register
        push_cmd(3'd0, 8'h00, 4'd0);
        wait_idle();
        ser_bits = 4'b1011;
        push_cmd(3'd5, 8'b0000_1011, 4'd4);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("ser_ctrl", 32'(sr_ctrl), 32'd5);
            check("ser_bit", 32'(sr_in[0]), 32'(ser_bits[i]));
        end
        @(posedge clk); #1;
        check("ser_result", 32'(sr_q), 32'hB0);
        wait_idle();

        // Six long commands against a 4-deep FIFO
        d0 = done_cnt;
        max_level = 0;
        for (int i = 0; i < 6; i++) begin
            push_cmd(3'(2 + i), 8'(8'h3C + i * 8'h11), 4'd7);
        end
        wait_idle();
        check("burst_dones", 32'(done_cnt - d0), 32'd6);
        check("burst_max_level", 32'(max_level), 32'(DEPTH));
        check("burst_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of a long command
        d0 = done_cnt;
        push_cmd(3'd3, 8'h00, 4'd10);
        push_cmd(3'd1, 8'h5A, 4'd2);
        push_cmd(3'd2, 8'h00, 4'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ctrl", 32'(sr_ctrl), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_q = '0;
        repeat (15) @(negedge clk);
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_hold_in", 32'(sr_in), 32'(sr_q));

        // Count of zero behaves as one cycle
        push_cmd(3'd1, 8'h0F, 4'd0);
        wait_idle();
        check("cnt0_q", 32'(sr_q), 32'h0F);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
